// File: rtl/sys_array_thread_sequencer.sv
// Per-thread job sequencer: queues matmul jobs and walks one controller thread through load/comp locks.
// Optional watchdog enabled by defining SEQ_WATCHDOG_EN.
module sys_array_thread_sequencer #(
    parameter int ADDRWIDTH  = 16,
    parameter int THREAD     = 0,
    parameter int FIFO_DEPTH = 2,
    parameter int TAGWIDTH   = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [ADDRWIDTH-1:0] job_a_addr,
    input  logic [ADDRWIDTH-1:0] job_b_addr,
    input  logic [ADDRWIDTH-1:0] job_d_addr,
    input  logic [ADDRWIDTH-1:0] job_c_addr,
    input  logic [TAGWIDTH-1:0]  job_tag,
    output logic                 load_lock_req,
    output logic [ADDRWIDTH-1:0] b_addr,
    input  logic                 load_lock_res,
    input  logic                 load_finished,
    output logic                 comp_lock_req,
    output logic [ADDRWIDTH-1:0] a_addr,
    output logic [ADDRWIDTH-1:0] d_addr,
    output logic [ADDRWIDTH-1:0] c_addr,
    input  logic                 comp_lock_res,
    input  logic                 comp_finished,
    output logic                 done_valid,
    output logic [TAGWIDTH-1:0]  done_tag,
    input  logic                 done_ready,
    output logic                 busy,
    output logic                 err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDRWIDTH-1:0] a;
        logic [ADDRWIDTH-1:0] b;
        logic [ADDRWIDTH-1:0] d;
        logic [ADDRWIDTH-1:0] c;
        logic [TAGWIDTH-1:0]  tag;
    } job_t;

    typedef enum logic [2:0] {
        IDLE, LOAD_REQ, LOAD_RUN, COMP_REQ, COMP_RUN, DONE
    } state_t;

    state_t          state;
    job_t            act;
    job_t            mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    assign job_ready = (count != FULL);
    assign push      = job_valid && job_ready;
    assign pop       = (state == IDLE) && (count != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{a: job_a_addr, b: job_b_addr, d: job_d_addr,
                                 c: job_c_addr, tag: job_tag};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

`ifdef SEQ_WATCHDOG_EN
    logic [31:0] wd_cnt;
    logic        err_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            act   <= '0;
`ifdef SEQ_WATCHDOG_EN
            wd_cnt <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (pop) begin
                    act   <= mem[rd_ptr];
                    state <= LOAD_REQ;
                end
                LOAD_REQ: if (load_lock_res) state <= LOAD_RUN;
                LOAD_RUN: if (load_finished) state <= COMP_REQ;
                COMP_REQ: if (comp_lock_res) state <= COMP_RUN;
                COMP_RUN: if (comp_finished) state <= DONE;
                DONE:     if (done_ready)    state <= IDLE;
                default:  state <= IDLE;
            endcase
`ifdef SEQ_WATCHDOG_EN
            // Counter only advances while stuck in a RUN state; any exit clears it.
            if ((state == LOAD_RUN && !load_finished) ||
                (state == COMP_RUN && !comp_finished)) begin
                if (wd_cnt == 32'(TIMEOUT - 1)) begin
                    err_q  <= 1'b1;
                    state  <= DONE;
                    wd_cnt <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 32'd1;
                end
            end else begin
                wd_cnt <= '0;
            end
`endif
        end
    end

`ifdef SEQ_WATCHDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        load_lock_req = (state == LOAD_REQ);
        comp_lock_req = (state == COMP_REQ);
        done_valid    = (state == DONE);
        b_addr        = (state == LOAD_REQ || state == LOAD_RUN) ? act.b : '0;
        a_addr        = '0;
        d_addr        = '0;
        c_addr        = '0;
        if (state == COMP_REQ || state == COMP_RUN) begin
            a_addr = act.a;
            d_addr = act.d;
            c_addr = act.c;
        end
        done_tag = done_valid ? act.tag : '0;
        busy     = (state != IDLE) || (count != '0);
    end

    assert property (@(posedge clock) disable iff (reset)
        (THREAD == 0 || THREAD == 1) && TIMEOUT > 0 && !(load_lock_req && comp_lock_req));

endmodule

// File: tb/tb_sys_array_thread_sequencer.sv
// Directed self-checking bench for sys_array_thread_sequencer (watchdog case runs when SEQ_WATCHDOG_EN is defined).
module tb_sys_array_thread_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        job_valid;
    logic        job_ready;
    logic [15:0] job_a_addr, job_b_addr, job_d_addr, job_c_addr;
    logic [7:0]  job_tag;
    logic        load_lock_req;
    logic [15:0] b_addr;
    logic        load_lock_res;
    logic        load_finished;
    logic        comp_lock_req;
    logic [15:0] a_addr, d_addr, c_addr;
    logic        comp_lock_res;
    logic        comp_finished;
    logic        done_valid;
    logic [7:0]  done_tag;
    logic        done_ready;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    sys_array_thread_sequencer #(
        .ADDRWIDTH (16),
        .THREAD    (0),
        .FIFO_DEPTH(2),
        .TAGWIDTH  (8),
        .TIMEOUT   (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_a_addr   (job_a_addr),
        .job_b_addr   (job_b_addr),
        .job_d_addr   (job_d_addr),
        .job_c_addr   (job_c_addr),
        .job_tag      (job_tag),
        .load_lock_req(load_lock_req),
        .b_addr       (b_addr),
        .load_lock_res(load_lock_res),
        .load_finished(load_finished),
        .comp_lock_req(comp_lock_req),
        .a_addr       (a_addr),
        .d_addr       (d_addr),
        .c_addr       (c_addr),
        .comp_lock_res(comp_lock_res),
        .comp_finished(comp_finished),
        .done_valid   (done_valid),
        .done_tag     (done_tag),
        .done_ready   (done_ready),
        .busy         (busy),
        .err          (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_job(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] d, input logic [15:0] c, input logic [7:0] t);
        job_valid  = 1'b1;
        job_a_addr = a;
        job_b_addr = b;
        job_d_addr = d;
        job_c_addr = c;
        job_tag    = t;
    endtask

    // Waits (bounded) for the load request, then walks the job through to completion.
    task automatic complete_job(input logic [7:0] exp_tag);
        for (int i = 0; i < 20 && !load_lock_req; i++) tick();
        check("wait_load_req", 32'(load_lock_req), 1);
        load_lock_res = 1'b1; tick(); load_lock_res = 1'b0;
        tick();
        load_finished = 1'b1; tick(); load_finished = 1'b0;
        check("cj_comp_req", 32'(comp_lock_req), 1);
        comp_lock_res = 1'b1; tick(); comp_lock_res = 1'b0;
        comp_finished = 1'b1; tick(); comp_finished = 1'b0;
        check("cj_done_valid", 32'(done_valid), 1);
        check("cj_done_tag", 32'(done_tag), 32'(exp_tag));
        done_ready = 1'b1; tick(); done_ready = 1'b0;
        check("cj_idle", 32'(done_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int seen_done;
        int seen_req;

        reset = 1'b1;
        job_valid = 1'b0; job_a_addr = '0; job_b_addr = '0; job_d_addr = '0; job_c_addr = '0; job_tag = '0;
        load_lock_res = 1'b0; load_finished = 1'b0; comp_lock_res = 1'b0; comp_finished = 1'b0;
        done_ready = 1'b0;
        #1;
        check("rst_job_ready", 32'(job_ready), 1);
        check("rst_load_req", 32'(load_lock_req), 0);
        check("rst_comp_req", 32'(comp_lock_req), 0);
        check("rst_done_valid", 32'(done_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single job with delayed grants; address windows checked per state.
        set_job(16'h10, 16'h20, 16'h30, 16'h40, 8'd5);
        tick();
        job_valid = 1'b0;
        check("t1_not_yet_req", 32'(load_lock_req), 0);
        check("t1_busy", 32'(busy), 1);
        check("t1_b_before", 32'(b_addr), 0);
        tick();
        check("t1_load_req", 32'(load_lock_req), 1);
        check("t1_b_req", 32'(b_addr), 32'h20);
        check("t1_a_in_load", 32'(a_addr), 0);
        tick();
        check("t1_load_req_hold", 32'(load_lock_req), 1);
        load_lock_res = 1'b1; tick(); load_lock_res = 1'b0;
        check("t1_req_dropped", 32'(load_lock_req), 0);
        check("t1_b_run", 32'(b_addr), 32'h20);
        for (int i = 0; i < 6; i++) tick();
        check("t1_b_run_late", 32'(b_addr), 32'h20);
        load_finished = 1'b1; tick(); load_finished = 1'b0;
        check("t1_comp_req", 32'(comp_lock_req), 1);
        check("t1_b_comp", 32'(b_addr), 0);
        check("t1_a", 32'(a_addr), 32'h10);
        check("t1_d", 32'(d_addr), 32'h30);
        check("t1_c", 32'(c_addr), 32'h40);
        comp_lock_res = 1'b1; tick(); comp_lock_res = 1'b0;
        check("t1_comp_req_drop", 32'(comp_lock_req), 0);
        check("t1_c_run", 32'(c_addr), 32'h40);
        comp_finished = 1'b1; tick(); comp_finished = 1'b0;
        check("t1_done_valid", 32'(done_valid), 1);
        check("t1_done_tag", 32'(done_tag), 5);
        check("t1_a_done", 32'(a_addr), 0);

        // Backpressure: completion held for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(done_valid), 1);
            check("bp_tag", 32'(done_tag), 5);
            check("bp_no_req", 32'(load_lock_req), 0);
        end
        done_ready = 1'b1; tick(); done_ready = 1'b0;
        check("t1_idle_valid", 32'(done_valid), 0);
        check("t1_idle_busy", 32'(busy), 0);

        // Stray finished pulses while in LOAD_REQ are ignored.
        set_job(16'h1, 16'h2, 16'h3, 16'h4, 8'd7);
        tick(); job_valid = 1'b0;
        tick();
        check("st_load_req", 32'(load_lock_req), 1);
        load_finished = 1'b1; comp_finished = 1'b1; tick();
        load_finished = 1'b0; comp_finished = 1'b0;
        check("st_still_req", 32'(load_lock_req), 1);
        check("st_no_comp", 32'(comp_lock_req), 0);
        check("st_no_done", 32'(done_valid), 0);
        tick();
        check("st_still_req2", 32'(load_lock_req), 1);
        complete_job(8'd7);

        // FIFO full: three back-to-back pushes with no grants.
        set_job(16'h100, 16'h200, 16'h300, 16'h400, 8'd0);
        tick();
        check("ff_ready1", 32'(job_ready), 1);
        job_tag = 8'd1; tick();
        check("ff_ready2", 32'(job_ready), 1);
        job_tag = 8'd2; tick();
        job_valid = 1'b0;
        check("ff_full", 32'(job_ready), 0);
        check("ff_load_req", 32'(load_lock_req), 1);
        complete_job(8'd0);
        check("ff_gap", 32'(load_lock_req), 0);
        tick();
        check("ff_next_req", 32'(load_lock_req), 1);
        check("ff_ready_again", 32'(job_ready), 1);
        complete_job(8'd1);
        complete_job(8'd2);
        check("ff_empty_busy", 32'(busy), 0);

        // Reset in COMP_RUN with one job still queued.
        set_job(16'h11, 16'h22, 16'h33, 16'h44, 8'd8);
        tick();
        job_tag = 8'd9; tick();
        job_valid = 1'b0;
        load_lock_res = 1'b1; tick(); load_lock_res = 1'b0;
        load_finished = 1'b1; tick(); load_finished = 1'b0;
        comp_lock_res = 1'b1; tick(); comp_lock_res = 1'b0;
        check("rr_in_comp_run", 32'(a_addr), 32'h11);
        #2 reset = 1'b1;
        #1;
        check("rr_a", 32'(a_addr), 0);
        check("rr_c", 32'(c_addr), 0);
        check("rr_ready", 32'(job_ready), 1);
        check("rr_busy", 32'(busy), 0);
        check("rr_done", 32'(done_valid), 0);
        tick();
        reset = 1'b0;
        seen_done = 0;
        seen_req = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_valid) seen_done++;
            if (load_lock_req) seen_req++;
        end
        check("rr_no_done_after", 32'(seen_done), 0);
        check("rr_no_req_after", 32'(seen_req), 0);

`ifdef SEQ_WATCHDOG_EN
        // Watchdog: stuck in LOAD_RUN for TIMEOUT cycles forces DONE.
        set_job(16'h5, 16'h6, 16'h7, 16'h8, 8'd3);
        tick(); job_valid = 1'b0;
        tick();
        load_lock_res = 1'b1; tick(); load_lock_res = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("wd_err_early", 32'(err), 0);
        check("wd_not_done", 32'(done_valid), 0);
        tick();
        check("wd_err", 32'(err), 1);
        check("wd_done", 32'(done_valid), 1);
        check("wd_tag", 32'(done_tag), 3);
        done_ready = 1'b1; tick(); done_ready = 1'b0;
        check("wd_sticky", 32'(err), 1);
`else
        check("err_tied", 32'(err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
